// File: rtl/clint_responder.sv
// CLINT target: msip, mtimecmp and a free-running mtime behind
// a single-outstanding valid/ready request/response channel.
module clint_responder #(
  parameter logic [63:0] BASE         = 64'h2000000,
  parameter int          RESP_LATENCY = 1,
  parameter int          TICK_DIV     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mtip,
  output logic        msip_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;
  logic   enter_resp;

  logic [63:0] mtime, mtimecmp;
  logic        msip;
  logic [31:0] tick_cnt, wait_cnt;
  logic        tick;

  logic [63:0] l_addr, l_wdata;
  logic        l_we, l_signed;
  logic [1:0]  l_size;

  logic [63:0] c_addr, c_wdata;
  logic        c_we, c_signed;
  logic [1:0]  c_size;

  logic [63:0] off, szmask, wmask, wval;
  logic [63:0] cur, raw, rext, merged;
  logic [5:0]  sh;
  logic        sel_msip, sel_cmp, sel_time;
  logic        misal, err, sbit;

  assign msip_o = msip;
  assign tick   = (tick_cnt == 32'(TICK_DIV - 1));

  // Live request while idle (latency-1 commits on the
  // handshake edge), latched copy afterwards.
  always_comb begin
    if (state == IDLE) begin
      c_addr   = req_addr;
      c_we     = req_we;
      c_size   = req_size;
      c_signed = req_signed;
      c_wdata  = req_wdata;
    end else begin
      c_addr   = l_addr;
      c_we     = l_we;
      c_size   = l_size;
      c_signed = l_signed;
      c_wdata  = l_wdata;
    end
  end

  // Decode, lane extraction and store merge.
  always_comb begin
    off      = c_addr - BASE;
    sel_msip = (off[63:3] == 61'h0);
    sel_cmp  = (off[63:3] == 61'h800);
    sel_time = (off[63:3] == 61'h17FF);
    sh       = {off[2:0], 3'b000};
    szmask   = '1;
    misal    = 1'b0;
    unique case (c_size)
      2'd0: szmask = 64'hFF;
      2'd1: begin
        szmask = 64'hFFFF;
        misal  = off[0];
      end
      2'd2: begin
        szmask = 64'hFFFF_FFFF;
        misal  = |off[1:0];
      end
      default: begin
        szmask = '1;
        misal  = |off[2:0];
      end
    endcase
    err = misal | ~(sel_msip | sel_cmp | sel_time);
    cur = mtime;
    unique case (1'b1)
      sel_msip: cur = {63'b0, msip};
      sel_cmp:  cur = mtimecmp;
      default:  cur = mtime;
    endcase
    raw  = (cur >> sh) & szmask;
    sbit = 1'b0;
    unique case (c_size)
      2'd0:    sbit = raw[7];
      2'd1:    sbit = raw[15];
      2'd2:    sbit = raw[31];
      default: sbit = 1'b0;
    endcase
    rext   = (c_signed && sbit) ? (raw | ~szmask) : raw;
    wmask  = szmask << sh;
    wval   = (c_wdata & szmask) << sh;
    merged = (cur & ~wmask) | wval;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (RESP_LATENCY > 1) begin
            state_n = WAIT;
          end else begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 32'(RESP_LATENCY - 2)) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Timer, interrupt, request latch and commit on RESP entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      mtip       <= 1'b0;
      tick_cnt   <= '0;
      wait_cnt   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      l_addr     <= '0;
      l_we       <= 1'b0;
      l_size     <= '0;
      l_signed   <= 1'b0;
      l_wdata    <= '0;
    end else begin
      mtip     <= (mtime >= mtimecmp);
      tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
      if (tick) mtime <= mtime + 64'd1;
      wait_cnt <= (state == WAIT) ? wait_cnt + 32'd1 : '0;
      if (req_valid && req_ready) begin
        l_addr   <= req_addr;
        l_we     <= req_we;
        l_size   <= req_size;
        l_signed <= req_signed;
        l_wdata  <= req_wdata;
      end
      if (enter_resp) begin
        resp_err   <= err;
        resp_rdata <= (err || c_we) ? '0 : rext;
        // a store to mtime overrides the tick above
        if (c_we && !err) begin
          if (sel_msip) msip     <= merged[0];
          if (sel_cmp)  mtimecmp <= merged;
          if (sel_time) mtime    <= merged;
        end
      end
    end
  end

endmodule

// File: tb/tb_clint_responder.sv
// Bench for clint_responder: byte-level behavioural model
// compared every cycle, plus hand-computed literals.
module tb_clint_responder;

  localparam logic [63:0] BASE = 64'h2000000;
  localparam int LAT = 3;
  localparam int TD  = 1;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mtip;
  logic        msip_o;

  clint_responder #(
    .BASE(BASE),
    .RESP_LATENCY(LAT),
    .TICK_DIV(TD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_we(req_we),
    .req_size(req_size),
    .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mtip(mtip),
    .msip_o(msip_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model state
  logic [63:0] m_mtime, m_cmp, m_rdata, m_addr, m_wdata;
  logic        m_msip, m_mtip, m_busy, m_resp, m_err;
  logic        m_we, m_sgn;
  logic [1:0]  m_size;
  int          m_due, m_tcnt;
  logic [63:0] om, oc;
  logic        oms;

  function automatic void commit(input logic [63:0] tm,
                                 input logic [63:0] tc,
                                 input logic        ts);
    int nb, lane, region;
    logic [63:0] off, cur, nv;
    nb  = 1 << m_size;
    off = m_addr - BASE;
    if (off < 64'h8) region = 0;
    else if (off >= 64'h4000 && off < 64'h4008) region = 1;
    else if (off >= 64'hBFF8 && off < 64'hC000) region = 2;
    else region = -1;
    m_rdata = '0;
    if (region < 0 || (m_addr % 64'(nb)) != 0) begin
      m_err = 1'b1;
      return;
    end
    m_err = 1'b0;
    cur = (region == 0) ? {63'b0, ts} :
          (region == 1) ? tc : tm;
    lane = int'(off % 64'd8);
    if (!m_we) begin
      for (int i = 0; i < nb; i++)
        m_rdata[8*i +: 8] = cur[8*(lane+i) +: 8];
      if (m_sgn && nb < 8 && m_rdata[8*nb-1])
        for (int i = nb; i < 8; i++)
          m_rdata[8*i +: 8] = 8'hFF;
    end else begin
      nv = cur;
      for (int i = 0; i < nb; i++)
        nv[8*(lane+i) +: 8] = m_wdata[8*i +: 8];
      if (region == 0) m_msip = nv[0];
      else if (region == 1) m_cmp = nv;
      else m_mtime = nv;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mtime = '0;
      m_cmp   = ONES;
      m_msip  = 1'b0;
      m_mtip  = 1'b0;
      m_busy  = 1'b0;
      m_resp  = 1'b0;
      m_rdata = '0;
      m_err   = 1'b0;
      m_due   = 0;
      m_tcnt  = 0;
    end else begin
      om = m_mtime;
      oc = m_cmp;
      oms = m_msip;
      m_mtip = (om >= oc);
      m_tcnt++;
      if (m_tcnt == TD) begin
        m_tcnt = 0;
        m_mtime = om + 64'd1;
      end
      if (m_resp) begin
        if (resp_ready) m_resp = 1'b0;
      end else if (!m_busy && req_valid) begin
        m_addr  = req_addr;
        m_we    = req_we;
        m_size  = req_size;
        m_sgn   = req_signed;
        m_wdata = req_wdata;
        m_busy  = 1'b1;
        m_due   = LAT;
      end
      if (m_busy) begin
        m_due--;
        if (m_due == 0) begin
          m_busy = 1'b0;
          m_resp = 1'b1;
          commit(om, oc, oms);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("req_ready", 64'(req_ready), 64'(!m_busy && !m_resp));
    chk("resp_valid", 64'(resp_valid), 64'(m_resp));
    chk("mtip", 64'(mtip), 64'(m_mtip));
    chk("msip_o", 64'(msip_o), 64'(m_msip));
    if (m_resp) begin
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_err", 64'(resp_err), 64'(m_err));
    end
  end

  task automatic wait_resp(output logic [63:0] rd,
                           output logic er);
    int n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) chk("resp_timeout", 64'(resp_valid), 64'd1);
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic xact(input logic [63:0] addr, input logic we,
                      input logic [1:0] size, input logic sgn,
                      input logic [63:0] wdata,
                      output logic [63:0] rd, output logic er);
    int n = 0;
    req_valid  = 1'b1;
    req_addr   = addr;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_wdata  = wdata;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_timeout", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(rd, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] rd, rd0;
  logic        er;
  int          n;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_mtip", 64'(mtip), 64'd0);
    chk("rst_msip_o", 64'(msip_o), 64'd0);
    rst = 1'b0;
    // accept on 4th edge, commit on 6th: samples mtime=5
    repeat (3) @(negedge clk);
    xact(BASE + 64'hBFF8, 0, 2'd3, 0, 0, rd, er);
    chk("mtime_after_5", rd, 64'd5);

    xact(BASE + 64'h4000, 1, 2'd3, 0, 64'h10, rd, er);
    chk("cmp_store_err", 64'(er), 64'd0);
    repeat (5) @(negedge clk);
    chk("mtip_before", 64'(mtip), 64'd0);
    @(negedge clk);
    chk("mtip_rise", 64'(mtip), 64'd1);

    xact(BASE + 64'h4000, 1, 2'd3, 0, ONES, rd, er);
    chk("mtip_fall", 64'(mtip), 64'd0);

    xact(BASE, 1, 2'd0, 0, 64'h01, rd, er);
    xact(BASE, 0, 2'd2, 0, 0, rd, er);
    chk("msip_read", rd, 64'h1);
    chk("msip_o_set", 64'(msip_o), 64'd1);

    xact(BASE, 1, 2'd2, 0, 64'hFFFF_FFFF, rd, er);
    xact(BASE, 0, 2'd2, 0, 0, rd, er);
    chk("msip_wmask", rd, 64'h1);
    xact(BASE, 1, 2'd2, 0, 0, rd, er);
    chk("msip_o_clr", 64'(msip_o), 64'd0);

    xact(BASE + 64'hBFF8, 1, 2'd3, 0, 64'h8000_0000_0000_0000, rd, er);
    xact(BASE + 64'hBFFF, 0, 2'd0, 1, 0, rd, er);
    chk("ld_sbyte", rd, 64'hFFFF_FFFF_FFFF_FF80);
    xact(BASE + 64'hBFFF, 0, 2'd0, 0, 0, rd, er);
    chk("ld_ubyte", rd, 64'h80);

    xact(BASE + 64'hBFF9, 0, 2'd1, 0, 0, rd, er);
    chk("misal_err", 64'(er), 64'd1);
    chk("misal_rdata", rd, 64'd0);

    xact(BASE + 64'h1000, 1, 2'd2, 0, 64'h1234_5678, rd, er);
    chk("unmap_err", 64'(er), 64'd1);
    xact(BASE + 64'h4000, 0, 2'd3, 0, 0, rd, er);
    chk("unmap_cmp_kept", rd, ONES);
    xact(BASE - 64'd8, 0, 2'd3, 0, 0, rd, er);
    chk("below_err", 64'(er), 64'd1);

    // Back-pressure with a second request held pending
    req_valid  = 1'b1;
    req_addr   = BASE + 64'h4000;
    req_we     = 1'b0;
    req_size   = 2'd3;
    req_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!resp_valid && n < 50) begin
      chk("bp_wait_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      n++;
    end
    rd0 = resp_rdata;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_rdata", resp_rdata, ONES);
      @(negedge clk);
    end
    chk("bp_stable", resp_rdata, rd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_idle_ready", 64'(req_ready), 64'd1);
    chk("bp_idle_valid", 64'(resp_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_2nd_accepted", 64'(req_ready), 64'd0);
    wait_resp(rd, er);
    chk("bp_2nd_rdata", rd, ONES);

    // store wins over the concurrent tick
    xact(BASE + 64'hBFF8, 1, 2'd3, 0, 64'd100, rd, er);
    xact(BASE + 64'hBFF8, 0, 2'd3, 0, 0, rd, er);
    chk("mtime_store_win", rd, 64'd103);

    // reset while the store to mtimecmp waits
    req_valid  = 1'b1;
    req_addr   = BASE + 64'h4000;
    req_we     = 1'b1;
    req_size   = 2'd3;
    req_wdata  = 64'd5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_valid", 64'(resp_valid), 64'd0);
    repeat (3) @(negedge clk);
    xact(BASE + 64'h4000, 0, 2'd3, 0, 0, rd, er);
    chk("rst_mid_cmp", rd, ONES);
    xact(BASE + 64'h4004, 0, 2'd2, 1, 0, rd, er);
    chk("cmp_hi_signed", rd, ONES);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
